trap_controller: RTL and testbench

//  Machine-mode trap unit; subscriber end of exception_if. Prioritises sync exception flags, captures mepc/mcause,

---
 rtl/rv32ima_pkg.sv | 50 +++++
 rtl/exception_if.sv | 31 +++
 rtl/trap_cause_prio.sv | 31 +++
 rtl/trap_controller.sv | 207 ++++++++++++++++++++
 tb/tb_trap_controller.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32ima_pkg.sv
// Shared definitions for the machine-mode trap unit.
// Contents:
//   CSR_*          12-bit addresses of the implemented M-mode CSRs
//   exc_cause_e    synchronous exception cause codes (mcause[3:0])
//   csr_op_e       CSR instruction operation
//   trap_state_e   trap controller FSM states
//   MSTATUS_*      bit positions of the writable mstatus fields
//   csr_addr_legal helper: 1 when an address maps to an implemented CSR
package rv32ima_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [3:0] {
        EXC_INST_ADDR_MISALIGN = 4'd0,
        EXC_INST_ILLEGAL       = 4'd2,
        EXC_BREAKPOINT         = 4'd3,
        EXC_LOAD_MISALIGN      = 4'd4,
        EXC_STORE_AMO_MISALIGN = 4'd6,
        EXC_ECALL_M            = 4'd11
    } exc_cause_e;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    function automatic logic csr_addr_legal(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: csr_addr_legal = 1'b1;
            default:                         csr_addr_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exception_if.sv
// Exception bundle between the pipeline (publisher) and the trap unit (subscriber).
// Signals:
//   inst_addr_misalign .. load_misalign  synchronous exception flags of the instruction in flight
//   current_pc         pc of that instruction
//   epc_value          mepc, used as the mret target
//   trap_handler_addr  fetch redirect target (mtvec, direct mode)
//   trap_enable        high while fetch must be redirected / the pipeline flushed
interface exception_if;
    logic        inst_addr_misalign;
    logic        inst_illegal;
    logic        ecall;
    logic        ebreak;
    logic        store_amo_misalign;
    logic        load_misalign;
    logic [31:0] current_pc;
    logic [31:0] epc_value;
    logic [31:0] trap_handler_addr;
    logic        trap_enable;

    modport publisher (
        output inst_addr_misalign, inst_illegal, ecall, ebreak,
               store_amo_misalign, load_misalign, current_pc,
        input  epc_value, trap_handler_addr, trap_enable
    );

    modport subscriber (
        input  inst_addr_misalign, inst_illegal, ecall, ebreak,
               store_amo_misalign, load_misalign, current_pc,
        output epc_value, trap_handler_addr, trap_enable
    );
endinterface

// File: rtl/trap_cause_prio.sv
// Combinational priority encoder from synchronous exception flags to a cause code.
// Ports:
//   inst_addr_misalign, inst_illegal, ecall, ebreak, store_amo_misalign, load_misalign  in  flags
//   valid  out  any flag set
//   cause  out  highest-priority cause (order listed above, first wins)
module trap_cause_prio
    import rv32ima_pkg::*;
(
    input  logic       inst_addr_misalign,
    input  logic       inst_illegal,
    input  logic       ecall,
    input  logic       ebreak,
    input  logic       store_amo_misalign,
    input  logic       load_misalign,
    output logic       valid,
    output exc_cause_e cause
);

    always_comb begin
        valid = inst_addr_misalign | inst_illegal | ecall | ebreak |
                store_amo_misalign | load_misalign;
        cause = EXC_INST_ADDR_MISALIGN;
        if (inst_addr_misalign)      cause = EXC_INST_ADDR_MISALIGN;
        else if (inst_illegal)       cause = EXC_INST_ILLEGAL;
        else if (ecall)              cause = EXC_ECALL_M;
        else if (ebreak)             cause = EXC_BREAKPOINT;
        else if (store_amo_misalign) cause = EXC_STORE_AMO_MISALIGN;
        else if (load_misalign)      cause = EXC_LOAD_MISALIGN;
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap unit. Takes synchronous exceptions, captures mepc/mcause,
// redirects fetch to mtvec for REDIRECT_CYCLES cycles, and owns the M-mode
// trap CSRs together with the CSR-instruction and mret paths.
// Optional feature macro: TRAP_MTVAL_EN (adds mtval_in and a real mtval register;
// without it mtval reads 0 and ignores writes, address 0x343 stays legal).
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   exc           exception_if.subscriber (flags/current_pc in, epc/handler/trap_enable out)
//   csr_en        CSR instruction valid
//   csr_op        00 read, 01 write, 10 set, 11 clear
//   csr_addr      CSR address
//   csr_wdata     CSR operand
//   csr_rdata     old value of the addressed CSR (0 for unknown addresses)
//   csr_illegal   csr_en with an unimplemented address
//   mret          mret retiring
//   trap_busy     high in REDIRECT; doubles as the visible FSM state
//   mtval_in      faulting address/instruction (TRAP_MTVAL_EN only)
// Handshake: there is no back-pressure. Inputs are sampled every rising edge
// while in RUN; while trap_busy is high all flags, csr_en and mret are dropped.
module trap_controller
    import rv32ima_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET     = 32'h0000_0100,
    parameter int unsigned REDIRECT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    exception_if.subscriber exc,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        mret,
`ifdef TRAP_MTVAL_EN
    input  logic [31:0] mtval_in,
`endif
    output logic        trap_busy
);

    localparam logic [3:0] CNT_INIT = 4'(REDIRECT_CYCLES - 1);

    trap_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_rd;
`ifdef TRAP_MTVAL_EN
    logic [31:0] mtval_q, mtval_d;
`endif

    logic        trap_valid;
    exc_cause_e  trap_cause;
    logic [31:0] mstatus_rd;
    logic [31:0] csr_new;
    logic        csr_we;

    trap_cause_prio u_prio (
        .inst_addr_misalign (exc.inst_addr_misalign),
        .inst_illegal       (exc.inst_illegal),
        .ecall              (exc.ecall),
        .ebreak             (exc.ebreak),
        .store_amo_misalign (exc.store_amo_misalign),
        .load_misalign      (exc.load_misalign),
        .valid              (trap_valid),
        .cause              (trap_cause)
    );

`ifdef TRAP_MTVAL_EN
    assign mtval_rd = mtval_q;
`else
    assign mtval_rd = 32'h0;
`endif

    // MPP is hardwired to machine mode (bits 12:11).
    always_comb begin
        mstatus_rd               = 32'h0000_1800;
        mstatus_rd[MSTATUS_MIE]  = mie_q;
        mstatus_rd[MSTATUS_MPIE] = mpie_q;
    end

    // CSR read mux and read-modify-write value.
    always_comb begin
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_rd;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_rd;
            default:      csr_rdata = 32'h0;
        endcase

        case (csr_op_e'(csr_op))
            CSR_OP_WRITE: csr_new = csr_wdata;
            CSR_OP_SET:   csr_new = csr_rdata | csr_wdata;
            CSR_OP_CLEAR: csr_new = csr_rdata & ~csr_wdata;
            default:      csr_new = csr_rdata;
        endcase

        csr_illegal = csr_en & ~csr_addr_legal(csr_addr);
        csr_we      = csr_en & csr_addr_legal(csr_addr) &
                      (csr_op != CSR_OP_READ);
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
`ifdef TRAP_MTVAL_EN
        mtval_d    = mtval_q;
`endif

        case (state_q)
            ST_RUN: begin
                if (trap_valid) begin
                    // The faulting instruction's CSR access / mret is squashed.
                    mepc_d   = {exc.current_pc[31:2], 2'b00};
                    mcause_d = {28'h0, trap_cause};
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
`ifdef TRAP_MTVAL_EN
                    mtval_d  = mtval_in;
`endif
                    cnt_d    = CNT_INIT;
                    state_d  = ST_REDIRECT;
                end else begin
                    if (csr_we) begin
                        case (csr_addr)
                            CSR_MSTATUS: begin
                                mie_d  = csr_new[MSTATUS_MIE];
                                mpie_d = csr_new[MSTATUS_MPIE];
                            end
                            CSR_MTVEC:    mtvec_d    = {csr_new[31:2], 2'b00};
                            CSR_MSCRATCH: mscratch_d = csr_new;
                            CSR_MEPC:     mepc_d     = {csr_new[31:2], 2'b00};
                            CSR_MCAUSE:   mcause_d   = csr_new;
`ifdef TRAP_MTVAL_EN
                            CSR_MTVAL:    mtval_d    = csr_new;
`endif
                            default: ;
                        endcase
                    end
                    // Placed after the CSR write so mret's MIE/MPIE update wins.
                    if (mret) begin
                        mie_d  = mpie_q;
                        mpie_d = 1'b1;
                    end
                end
            end
            ST_REDIRECT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
`ifdef TRAP_MTVAL_EN
            mtval_q    <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
`ifdef TRAP_MTVAL_EN
            mtval_q    <= mtval_d;
`endif
        end
    end

    // Driven straight from the state flop so reset drops it asynchronously.
    assign exc.trap_enable       = (state_q == ST_REDIRECT);
    assign trap_busy             = (state_q == ST_REDIRECT);
    assign exc.trap_handler_addr = {mtvec_q[31:2], 2'b00};
    assign exc.epc_value         = mepc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Testbench for trap_controller: directed scenarios followed by randomized
// traffic, all compared against an architectural model of the trap CSRs.
module tb_trap_controller;

    localparam int          RC        = 3;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        mret;
    logic        trap_busy;
    logic [31:0] mtval_in;

    exception_if exc_if ();

    trap_controller #(
        .MTVEC_RESET     (MTVEC_RST),
        .REDIRECT_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exc         (exc_if),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .mret        (mret),
`ifdef TRAP_MTVAL_EN
        .mtval_in    (mtval_in),
`endif
        .trap_busy   (trap_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural model state.
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;
    int          m_left;   // cycles of trap_enable still owed

    // Flag order in the 6-bit vector: inst_addr_misalign, inst_illegal, ecall,
    // ebreak, store_amo_misalign, load_misalign -- also the priority order.
    int prio_code[6] = '{0, 2, 11, 3, 6, 4};
    logic [5:0] cur_flags;

    logic [11:0] addr_pool[8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h7C0, 12'h301};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_mie = 0; m_mpie = 0; m_left = 0;
    endtask

    function automatic bit m_legal(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) ||
               (a == 12'h341) || (a == 12'h342) || (a == 12'h343);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (32'(m_mpie) * 128) + (32'(m_mie) * 8);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef TRAP_MTVAL_EN
            12'h343: return m_mtval;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Apply one clock edge's worth of architectural effect.
    task automatic model_edge();
        logic [31:0] old_v, new_v;
        logic        old_mpie;
        if (m_left > 0) begin
            m_left--;
        end else if (cur_flags != 0) begin
            for (int i = 0; i < 6; i++) begin
                if (cur_flags[i]) begin
                    m_mcause = prio_code[i];
                    break;
                end
            end
            m_mepc  = exc_if.current_pc - (exc_if.current_pc % 4);
            m_mpie  = m_mie;
            m_mie   = 0;
            m_mtval = mtval_in;
            m_left  = RC;
        end else begin
            old_mpie = m_mpie;
            if (csr_en && m_legal(csr_addr) && csr_op != 2'b00) begin
                old_v = m_read(csr_addr);
                if (csr_op == 2'b01)      new_v = csr_wdata;
                else if (csr_op == 2'b10) new_v = old_v | csr_wdata;
                else                      new_v = old_v & ~csr_wdata;
                case (csr_addr)
                    12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
                    12'h305: m_mtvec    = new_v - (new_v % 4);
                    12'h340: m_mscratch = new_v;
                    12'h341: m_mepc     = new_v - (new_v % 4);
                    12'h342: m_mcause   = new_v;
`ifdef TRAP_MTVAL_EN
                    12'h343: m_mtval    = new_v;
`endif
                    default: ;
                endcase
            end
            if (mret) begin
                m_mie  = old_mpie;
                m_mpie = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_trap_enable"}, 32'(exc_if.trap_enable), 32'(m_left > 0));
        check({tag, "_trap_busy"},   32'(trap_busy),          32'(m_left > 0));
        check({tag, "_epc"},         exc_if.epc_value,        m_mepc);
        check({tag, "_handler"},     exc_if.trap_handler_addr, m_mtvec & 32'hFFFF_FFFC);
    endtask

    // One cycle: drive at the falling edge, check combinational CSR outputs,
    // take the rising edge, then check registered outputs.
    task automatic step(input string tag, input logic [5:0] f, input logic [31:0] pc,
                        input logic ce, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic mr, input logic [31:0] tv);
        cur_flags = f;
        exc_if.inst_addr_misalign = f[0];
        exc_if.inst_illegal       = f[1];
        exc_if.ecall              = f[2];
        exc_if.ebreak             = f[3];
        exc_if.store_amo_misalign = f[4];
        exc_if.load_misalign      = f[5];
        exc_if.current_pc         = pc;
        csr_en = ce; csr_op = op; csr_addr = a; csr_wdata = wd; mret = mr; mtval_in = tv;
        #1;
        check({tag, "_rdata"},   csr_rdata,          m_read(a));
        check({tag, "_illegal"}, 32'(csr_illegal),   32'(ce && !m_legal(a)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 6'd0, 32'h0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [11:0] a);
        step(tag, 6'd0, 32'h0, 1'b1, 2'b00, a, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        m_reset();
        rst = 1'b1;
        cur_flags = 0;
        exc_if.inst_addr_misalign = 0; exc_if.inst_illegal = 0; exc_if.ecall = 0;
        exc_if.ebreak = 0; exc_if.store_amo_misalign = 0; exc_if.load_misalign = 0;
        exc_if.current_pc = 0;
        csr_en = 0; csr_op = 0; csr_addr = 12'h300; csr_wdata = 0; mret = 0; mtval_in = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        // Reset state.
        check("rst_trap_enable", 32'(exc_if.trap_enable), 32'h0);
        check("rst_trap_busy",   32'(trap_busy),          32'h0);
        check("rst_handler",     exc_if.trap_handler_addr, 32'h100);
        check("rst_mstatus",     csr_rdata,               32'h1800);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) rd("rst_rd", addr_pool[i]);

        // 1: ecall traps with pc 0x2004.
        step("t1_ecall", 6'b000100, 32'h0000_2004, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 32'hA5A5_0001);
        check("t1_epc_const", exc_if.epc_value,         32'h2004);
        check("t1_addr_const", exc_if.trap_handler_addr, 32'h100);
        check("t1_te_const",  32'(exc_if.trap_enable),  32'h1);
        idle("t1_idle", RC);
        rd("t1_mcause", 12'h342);
        check("t1_mcause_const", csr_rdata, 32'd11);
        rd("t1_mtval", 12'h343);

        // 2: illegal + load misalign together -> cause 2, three redirect cycles.
        step("t2_trap", 6'b100010, 32'h0000_3003, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 32'h1234_5678);
        idle("t2_redirect", RC + 1);
        rd("t2_mcause", 12'h342);
        check("t2_mcause_const", csr_rdata, 32'd2);
        rd("t2_mepc", 12'h341);

        // 3: set MIE, trap, mret.
        step("t3_set_mie", 6'd0, 32'h0, 1'b1, 2'b10, 12'h300, 32'h8, 1'b0, 32'h0);
        rd("t3_mstatus1", 12'h300);
        step("t3_trap", 6'b000001, 32'h0000_4000, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 32'h0);
        idle("t3_redirect", RC);
        rd("t3_mstatus2", 12'h300);
        check("t3_mstatus2_const", csr_rdata, 32'h1880);
        step("t3_mret", 6'd0, 32'h0, 1'b0, 2'b00, 12'h0, 32'h0, 1'b1, 32'h0);
        rd("t3_mstatus3", 12'h300);
        check("t3_mstatus3_const", csr_rdata, 32'h1888);

        // 4: mtvec WARL and an unimplemented address.
        step("t4_wr_mtvec", 6'd0, 32'h0, 1'b1, 2'b01, 12'h305, 32'h8000_0003, 1'b0, 32'h0);
        rd("t4_rd_mtvec", 12'h305);
        check("t4_mtvec_const", csr_rdata, 32'h8000_0000);
        step("t4_illegal", 6'd0, 32'h0, 1'b1, 2'b01, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        check("t4_illegal_const", 32'(csr_illegal), 32'h1);

        // csr write to mstatus together with mret: mret's update wins.
        step("tx_csr_mret", 6'd0, 32'h0, 1'b1, 2'b01, 12'h300, 32'h0, 1'b1, 32'h0);
        rd("tx_mstatus", 12'h300);

        // 5: ebreak with a CSR write in the same cycle; flag during REDIRECT ignored.
        step("t5_ebreak", 6'b001000, 32'h0000_5008, 1'b1, 2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0);
        step("t5_ignored", 6'b000100, 32'h0000_6000, 1'b1, 2'b01, 12'h340, 32'h1111_1111, 1'b1, 32'h0);
        idle("t5_idle", RC);
        rd("t5_mscratch", 12'h340);
        check("t5_mscratch_const", csr_rdata, 32'h0);
        rd("t5_mcause", 12'h342);
        check("t5_mcause_const", csr_rdata, 32'd3);

        // 6: reset in the middle of REDIRECT.
        step("t6_trap", 6'b010000, 32'h0000_7010, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 32'h0BAD_0ADD);
        step("t6_mid", 6'd0, 32'h0, 1'b0, 2'b00, 12'h0, 32'h0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("t6_te_async", 32'(exc_if.trap_enable), 32'h0);
        check("t6_busy_async", 32'(trap_busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) rd("t6_rd", addr_pool[i]);
        idle("t6_idle", 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            step("rnd", f, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 addr_pool[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 4) == 0),
                 $urandom);
        end
        for (int i = 0; i < 6; i++) rd("end_rd", addr_pool[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
